// File: rtl/rf_op_sequencer_pkg.sv
// Shared types for the register-file op sequencer: op classes, FSM states,
// one-hot ALU op codes and the per-state strobe decode.
// Pure declarations and functions; no storage, no handshake of its own.
package rf_seq_pkg;

  typedef enum logic [3:0] {
    ALU_RR = 4'd0,
    ALU_RI = 4'd1,
    LOAD   = 4'd2,
    STORE  = 4'd3,
    BRANCH = 4'd4,
    JAL    = 4'd5,
    LUI    = 4'd6,
    AUIPC  = 4'd7
  } op_class_t;

  typedef enum logic [2:0] {
    IDLE, OPER, ADDR, MEM_WAIT, CMP, WB, DONE
  } state_t;

  localparam logic [3:0] FA_SUM = 4'b0001;
  localparam logic [3:0] FA_AND = 4'b0010;
  localparam logic [3:0] FA_XOR = 4'b0100;
  localparam logic [3:0] FA_OR  = 4'b1000;

  // Every registered strobe the sequencer drives, held as one word so a
  // whole cycle's worth of outputs is loaded in a single assignment.
  typedef struct packed {
    logic       write_en;
    logic       op_enable;
    logic       data2bus_en;
    logic       exp_go_up;
    logic       exp_go_dn;
    logic       buffer_read;
    logic       buffer_write;
    logic       buffer_go_up;
    logic       inv_en;
    logic       carry_in;
    logic       imm_en;
    logic       imm_up_en;
    logic       dataFM_en;
    logic       pc_plus_en;
    logic       pc_imm_en;
    logic       mem_req;
    logic       mem_we;
    logic       done;
    logic [3:0] op_fa;
  } strobe_t;

  // State entered straight out of IDLE for a given class; unknown classes
  // fall through to DONE so the requester still sees a completion.
  function automatic state_t first_state(op_class_t cls);
    case (cls)
      ALU_RR, ALU_RI:   return OPER;
      LOAD, STORE:      return ADDR;
      BRANCH:           return CMP;
      JAL, LUI, AUIPC:  return WB;
      default:          return DONE;
    endcase
  endfunction

  // Strobes that are valid for the whole time the FSM sits in state st.
  function automatic strobe_t entry_strobes(state_t st, op_class_t cls,
                                            logic [3:0] fa, logic sub);
    strobe_t s;
    s = '0;
    case (st)
      OPER: begin
        s.op_enable = 1'b1;
        if (cls == ALU_RI) s.imm_en      = 1'b1;
        else               s.data2bus_en = 1'b1;
        // Subtract is a + ~b + 1, which only works on the adder path.
        if (sub) begin
          s.inv_en   = 1'b1;
          s.carry_in = 1'b1;
          s.op_fa    = FA_SUM;
        end else begin
          s.op_fa    = fa;
        end
      end
      ADDR: begin
        s.op_enable   = 1'b1;
        s.exp_go_up   = 1'b1;
        s.imm_en      = 1'b1;
        s.op_fa       = FA_SUM;
        s.data2bus_en = (cls == STORE);
      end
      MEM_WAIT: begin
        s.mem_req = 1'b1;
        s.mem_we  = (cls == STORE);
      end
      CMP: begin
        s.op_enable    = 1'b1;
        s.data2bus_en  = 1'b1;
        s.exp_go_dn    = 1'b1;
        s.inv_en       = 1'b1;
        s.carry_in     = 1'b1;
        s.buffer_write = 1'b1;
      end
      WB: begin
        s.write_en = 1'b1;
        case (cls)
          LOAD:    s.dataFM_en  = 1'b1;
          JAL:     s.pc_plus_en = 1'b1;
          LUI:     begin s.imm_up_en = 1'b1; s.buffer_go_up = 1'b1; end
          AUIPC:   begin s.pc_imm_en = 1'b1; s.buffer_go_up = 1'b1; end
          default: ;
        endcase
      end
      DONE:    s.done = 1'b1;
      default: ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/rf_op_sequencer_if.sv
// Instruction, memory and register-file strobe bundle of the op sequencer.
// Wires only; no latency.
// in_valid/in_ready handshake; memory side completes on mem_ack.
// Ports: slave = sequencer (consumes instructions, drives strobes),
//        master = instruction/memory/comparator source.
interface rf_op_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] op_class;
  logic [4:0] rd_idx;
  logic [4:0] rs1_idx;
  logic [4:0] rs2_idx;
  logic [3:0] fa_op;
  logic       sub;
  logic       br_ne;
  logic       cmp_eq;
  logic       mem_ack;
  logic       mem_req;
  logic       mem_we;
  logic [4:0] rd_index;
  logic [4:0] rs1_index;
  logic [4:0] rs2_index;
  logic       write_en;
  logic       op_enable;
  logic       data2bus_en;
  logic       exp_go_up;
  logic       exp_go_dn;
  logic       buffer_read;
  logic       buffer_write;
  logic       buffer_go_up;
  logic       inv_en;
  logic       carry_in;
  logic       imm_en;
  logic       imm_up_en;
  logic       dataFM_en;
  logic       pc_plus_en;
  logic       pc_imm_en;
  logic [3:0] op_fa;
  logic       done;
  logic       br_taken;
  logic       mem_err;

  modport slave (
    input  in_valid, op_class, rd_idx, rs1_idx, rs2_idx, fa_op, sub, br_ne,
           cmp_eq, mem_ack,
    output in_ready, mem_req, mem_we, rd_index, rs1_index, rs2_index,
           write_en, op_enable, data2bus_en, exp_go_up, exp_go_dn,
           buffer_read, buffer_write, buffer_go_up, inv_en, carry_in, imm_en,
           imm_up_en, dataFM_en, pc_plus_en, pc_imm_en, op_fa, done,
           br_taken, mem_err
  );

  modport master (
    output in_valid, op_class, rd_idx, rs1_idx, rs2_idx, fa_op, sub, br_ne,
           cmp_eq, mem_ack,
    input  in_ready, mem_req, mem_we, rd_index, rs1_index, rs2_index,
           write_en, op_enable, data2bus_en, exp_go_up, exp_go_dn,
           buffer_read, buffer_write, buffer_go_up, inv_en, carry_in, imm_en,
           imm_up_en, dataFM_en, pc_plus_en, pc_imm_en, op_fa, done,
           br_taken, mem_err
  );
endinterface

// File: rtl/rf_op_sequencer_mem_timeout_cnt.sv
// Counts MEM_WAIT cycles and flags when the memory wait budget is used up.
// expired is combinational off the count register (no input-to-output path).
// No handshake; load restarts the count, enable advances it.
// Ports: clk, rst (sync active-low), load, enable in; expired out.
module mem_timeout_cnt #(
  parameter int MEM_TO = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expired
);
  localparam logic [3:0] LIMIT = 4'(MEM_TO);

  logic [3:0] cnt;

  // Load to 1 so the count equals the number of the MEM_WAIT cycle in
  // progress; expired then rises in the last allowed wait cycle.
  always_ff @(posedge clk) begin
    if (!rst)                     cnt <= 4'd0;
    else if (load)                cnt <= 4'd1;
    else if (enable && !expired)  cnt <= cnt + 4'd1;
  end

  assign expired = (cnt == LIMIT);
endmodule

// File: rtl/rf_op_sequencer.sv
// Sequences decoded instructions into register-file/memory strobe patterns.
// 1 cycle from handshake to first strobes; DONE pulses 1 cycle before IDLE.
// in_ready only in IDLE; MEM_WAIT holds on mem_ack, abandons after MEM_TO.
// Ports: clk, rst (sync active-low), bus (slave side of rf_op_sequencer_if).
module rf_op_sequencer
  import rf_seq_pkg::*;
#(
  parameter int COLS   = 32,
  parameter int MEM_TO = 15
) (
  input  logic                clk,
  input  logic                rst,
  rf_op_sequencer_if.slave    bus
);

  if (COLS < 1) begin : g_bad_cols
    $error("rf_op_sequencer: COLS must be at least 1");
  end
  if (MEM_TO < 1 || MEM_TO > 15) begin : g_bad_mem_to
    $error("rf_op_sequencer: MEM_TO must fit the 4-bit timeout counter");
  end

  state_t     state;
  op_class_t  cls_q;
  logic [3:0] fa_q;
  logic       sub_q;
  logic       br_ne_q;
  logic [4:0] rd_q;
  logic [4:0] rs1_q;
  logic [4:0] rs2_q;
  strobe_t    strb;
  logic       br_taken_q;
  logic       mem_err_q;
  logic       expired;
  op_class_t  cls_in;
  state_t     first_in;

  assign cls_in   = op_class_t'(bus.op_class);
  assign first_in = first_state(cls_in);

  mem_timeout_cnt #(.MEM_TO(MEM_TO)) u_mem_timeout_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (state == ADDR),
    .enable  (state == MEM_WAIT),
    .expired (expired)
  );

  // Outputs for a state are loaded on the edge that enters it, so every
  // strobe comes straight from a flop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cls_q      <= ALU_RR;
      fa_q       <= '0;
      sub_q      <= 1'b0;
      br_ne_q    <= 1'b0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      strb       <= '0;
      br_taken_q <= 1'b0;
      mem_err_q  <= 1'b0;
    end else begin
      strb       <= '0;
      br_taken_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            cls_q     <= cls_in;
            fa_q      <= bus.fa_op;
            sub_q     <= bus.sub;
            br_ne_q   <= bus.br_ne;
            rd_q      <= bus.rd_idx;
            rs1_q     <= bus.rs1_idx;
            rs2_q     <= bus.rs2_idx;
            mem_err_q <= 1'b0;
            state     <= first_in;
            strb      <= entry_strobes(first_in, cls_in, bus.fa_op, bus.sub);
          end
        end
        OPER: begin
          state <= WB;
          strb  <= entry_strobes(WB, cls_q, fa_q, sub_q);
        end
        ADDR: begin
          state <= MEM_WAIT;
          strb  <= entry_strobes(MEM_WAIT, cls_q, fa_q, sub_q);
        end
        MEM_WAIT: begin
          // An ack in the final allowed cycle wins over the timeout.
          if (bus.mem_ack) begin
            if (cls_q == LOAD) begin
              state <= WB;
              strb  <= entry_strobes(WB, cls_q, fa_q, sub_q);
            end else begin
              state <= DONE;
              strb  <= entry_strobes(DONE, cls_q, fa_q, sub_q);
            end
          end else if (expired) begin
            state     <= DONE;
            strb      <= entry_strobes(DONE, cls_q, fa_q, sub_q);
            mem_err_q <= 1'b1;
          end else begin
            strb <= entry_strobes(MEM_WAIT, cls_q, fa_q, sub_q);
          end
        end
        CMP: begin
          state      <= DONE;
          strb       <= entry_strobes(DONE, cls_q, fa_q, sub_q);
          br_taken_q <= bus.cmp_eq ^ br_ne_q;
        end
        WB: begin
          state <= DONE;
          strb  <= entry_strobes(DONE, cls_q, fa_q, sub_q);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready     = (state == IDLE);
  assign bus.rd_index     = rd_q;
  assign bus.rs1_index    = rs1_q;
  assign bus.rs2_index    = rs2_q;
  assign bus.write_en     = strb.write_en;
  assign bus.op_enable    = strb.op_enable;
  assign bus.data2bus_en  = strb.data2bus_en;
  assign bus.exp_go_up    = strb.exp_go_up;
  assign bus.exp_go_dn    = strb.exp_go_dn;
  assign bus.buffer_read  = strb.buffer_read;
  assign bus.buffer_write = strb.buffer_write;
  assign bus.buffer_go_up = strb.buffer_go_up;
  assign bus.inv_en       = strb.inv_en;
  assign bus.carry_in     = strb.carry_in;
  assign bus.imm_en       = strb.imm_en;
  assign bus.imm_up_en    = strb.imm_up_en;
  assign bus.dataFM_en    = strb.dataFM_en;
  assign bus.pc_plus_en   = strb.pc_plus_en;
  assign bus.pc_imm_en    = strb.pc_imm_en;
  assign bus.mem_req      = strb.mem_req;
  assign bus.mem_we       = strb.mem_we;
  assign bus.op_fa        = strb.op_fa;
  assign bus.done         = strb.done;
  assign bus.br_taken     = br_taken_q;
  assign bus.mem_err      = mem_err_q;

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Directed bench for rf_op_sequencer with a completion scoreboard.
// Inputs change and outputs are sampled 2 time units after the rising edge.
// A negedge monitor pops one expectation per done pulse.
module tb_rf_op_sequencer;
  import rf_seq_pkg::*;

  localparam logic [14:0] S_WE   = 15'h4000;
  localparam logic [14:0] S_OPEN = 15'h2000;
  localparam logic [14:0] S_D2B  = 15'h1000;
  localparam logic [14:0] S_EUP  = 15'h0800;
  localparam logic [14:0] S_EDN  = 15'h0400;
  localparam logic [14:0] S_BWR  = 15'h0100;
  localparam logic [14:0] S_BUP  = 15'h0080;
  localparam logic [14:0] S_INV  = 15'h0040;
  localparam logic [14:0] S_CIN  = 15'h0020;
  localparam logic [14:0] S_IMM  = 15'h0010;
  localparam logic [14:0] S_IUP  = 15'h0008;
  localparam logic [14:0] S_DFM  = 15'h0004;
  localparam logic [14:0] S_PCP  = 15'h0002;
  localparam logic [14:0] S_PCI  = 15'h0001;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_op_sequencer_if bus();

  rf_op_sequencer #(.COLS(32), .MEM_TO(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [14:0] strobes;
  logic [38:0] outs_all;
  assign strobes = {bus.write_en, bus.op_enable, bus.data2bus_en, bus.exp_go_up,
                    bus.exp_go_dn, bus.buffer_read, bus.buffer_write,
                    bus.buffer_go_up, bus.inv_en, bus.carry_in, bus.imm_en,
                    bus.imm_up_en, bus.dataFM_en, bus.pc_plus_en, bus.pc_imm_en};
  assign outs_all = {strobes, bus.mem_req, bus.mem_we, bus.done, bus.br_taken,
                     bus.mem_err, bus.op_fa, bus.rd_index, bus.rs1_index,
                     bus.rs2_index};

  typedef struct {
    logic br;
    logic merr;
    int   wb;
    int   len;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   errors   = 0;
  int   hs_total = 0;
  bit   mon_busy = 1'b0;
  int   mon_len  = 0;
  int   mon_wb   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Presents one instruction in IDLE, records what its completion must
  // look like, and returns in the first cycle after the handshake.
  task automatic issue(input op_class_t cls, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [3:0] fa, input logic sb, input logic brne,
                       input logic ceq, input logic exp_br, input logic exp_merr,
                       input int exp_wb, input int exp_len);
    exp_t e;
    bus.in_valid = 1'b1;
    bus.op_class = cls;
    bus.rd_idx   = rd;
    bus.rs1_idx  = rs1;
    bus.rs2_idx  = rs2;
    bus.fa_op    = fa;
    bus.sub      = sb;
    bus.br_ne    = brne;
    bus.cmp_eq   = ceq;
    e.br   = exp_br;
    e.merr = exp_merr;
    e.wb   = exp_wb;
    e.len  = exp_len;
    exp_q.push_back(e);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Walks MEM_WAIT, acking in wait cycle ack_at (0 = never); n returns the
  // number of cycles mem_req was seen high.
  task automatic run_mem(input int ack_at, output int n);
    n = 0;
    while (bus.mem_req && n < 20) begin
      n++;
      if (n == ack_at) bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
    end
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!bus.done && k < 40) begin
      tick();
      k++;
    end
    chk(tag, bus.done, 1);
    tick();
  endtask

  // Completion monitor: latency is counted in cycles from the handshake
  // cycle (0) to the done cycle, alongside the number of write_en cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        mon_busy = 1'b0;
      end else begin
        if (mon_busy) begin
          mon_len++;
          if (bus.write_en) mon_wb++;
        end
        if (bus.done) begin
          chk("sb_done_expected", {63'd0, mon_busy && (exp_q.size() != 0)}, 1);
          if (mon_busy && exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("sb_br_taken", bus.br_taken, mon_e.br);
            chk("sb_mem_err", bus.mem_err, mon_e.merr);
            chk("sb_wb_count", mon_wb, mon_e.wb);
            chk("sb_latency", mon_len, mon_e.len);
          end
          mon_busy = 1'b0;
        end
        if (bus.in_valid && bus.in_ready) begin
          mon_busy = 1'b1;
          mon_len  = 0;
          mon_wb   = 0;
          hs_total++;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int hs_before;
    exp_t e;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.op_class = 4'd0;
    bus.rd_idx   = '0;
    bus.rs1_idx  = '0;
    bus.rs2_idx  = '0;
    bus.fa_op    = '0;
    bus.sub      = 1'b0;
    bus.br_ne    = 1'b0;
    bus.cmp_eq   = 1'b0;
    bus.mem_ack  = 1'b0;
    tick();
    tick();
    chk("rst_outputs", outs_all, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    rst = 1'b1;
    tick();

    // ALU_RR subtract: forced adder op, inverted operand with carry.
    issue(ALU_RR, 5'd3, 5'd1, 5'd2, FA_XOR, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 3);
    chk("alu_rr_sub_oper", strobes, S_OPEN | S_D2B | S_INV | S_CIN);
    chk("alu_rr_sub_op_fa", bus.op_fa, 4'b0001);
    chk("alu_rr_indices", {bus.rd_index, bus.rs1_index, bus.rs2_index}, {5'd3, 5'd1, 5'd2});
    tick();
    chk("alu_rr_wb", strobes, S_WE);
    tick();
    chk("alu_rr_done", {bus.done, bus.write_en}, 2'b10);
    tick();
    chk("alu_rr_idle", {bus.in_ready, bus.done}, 2'b10);
    chk("alu_rr_index_hold", {bus.rd_index, bus.rs1_index, bus.rs2_index}, {5'd3, 5'd1, 5'd2});

    // ALU_RR without subtract passes the requested op through.
    issue(ALU_RR, 5'd9, 5'd10, 5'd11, FA_OR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 3);
    chk("alu_rr_or_oper", strobes, S_OPEN | S_D2B);
    chk("alu_rr_or_op_fa", bus.op_fa, 4'b1000);
    wait_done("alu_rr_or_done");

    // ALU_RI uses the immediate instead of the second register.
    issue(ALU_RI, 5'd4, 5'd5, 5'd0, FA_AND, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 3);
    chk("alu_ri_oper", strobes, S_OPEN | S_IMM);
    chk("alu_ri_op_fa", bus.op_fa, 4'b0010);
    wait_done("alu_ri_done");

    // LOAD acked in the fourth wait cycle.
    issue(LOAD, 5'd7, 5'd4, 5'd0, FA_XOR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 7);
    chk("load_addr", strobes, S_OPEN | S_EUP | S_IMM);
    chk("load_addr_op_fa", bus.op_fa, 4'b0001);
    tick();
    chk("load_mem_req_we", {bus.mem_req, bus.mem_we}, 2'b10);
    run_mem(4, n);
    chk("load_mem_req_cycles", n, 4);
    chk("load_wb", strobes, S_WE | S_DFM);
    tick();
    chk("load_done", {bus.done, bus.write_en, bus.mem_err}, 3'b100);
    tick();

    // STORE never acked: full timeout, no write-back, sticky error.
    issue(STORE, 5'd0, 5'd6, 5'd8, FA_SUM, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 17);
    chk("store_addr", strobes, S_OPEN | S_D2B | S_EUP | S_IMM);
    tick();
    chk("store_mem_req_we", {bus.mem_req, bus.mem_we}, 2'b11);
    run_mem(0, n);
    chk("store_timeout_cycles", n, 15);
    chk("store_timeout_done", {bus.done, bus.mem_err, bus.write_en}, 3'b110);
    tick();
    chk("mem_err_sticky_idle", {bus.in_ready, bus.mem_err}, 2'b11);
    tick();
    chk("mem_err_sticky_idle2", bus.mem_err, 1);

    // BNE with unequal operands is taken; the handshake clears mem_err.
    issue(BRANCH, 5'd0, 5'd1, 5'd2, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 2);
    chk("branch_cmp", strobes, S_OPEN | S_D2B | S_EDN | S_INV | S_CIN | S_BWR);
    chk("mem_err_cleared", bus.mem_err, 0);
    tick();
    chk("branch_bne_taken", {bus.done, bus.br_taken}, 2'b11);
    tick();
    chk("branch_br_taken_drop", bus.br_taken, 0);

    // BEQ with unequal operands is not taken.
    issue(BRANCH, 5'd0, 5'd3, 5'd4, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 2);
    tick();
    chk("branch_beq_not_taken", {bus.done, bus.br_taken}, 2'b10);
    tick();

    // BEQ with equal operands is taken.
    issue(BRANCH, 5'd0, 5'd3, 5'd3, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 2);
    tick();
    chk("branch_beq_taken", {bus.done, bus.br_taken}, 2'b11);
    tick();

    // STORE acked in the very last allowed wait cycle counts as success.
    issue(STORE, 5'd0, 5'd2, 5'd9, FA_SUM, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 17);
    tick();
    run_mem(15, n);
    chk("store_late_ack_cycles", n, 15);
    chk("store_late_ack_done", {bus.done, bus.mem_err, bus.write_en}, 3'b100);
    tick();

    issue(LUI, 5'd12, 5'd0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 2);
    chk("lui_wb", strobes, S_WE | S_IUP | S_BUP);
    wait_done("lui_done");

    issue(AUIPC, 5'd13, 5'd0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 2);
    chk("auipc_wb", strobes, S_WE | S_PCI | S_BUP);
    wait_done("auipc_done");

    // Unknown class completes immediately with nothing else driven.
    issue(op_class_t'(4'hC), 5'd1, 5'd1, 5'd1, FA_OR, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1);
    chk("undef_done", {bus.done, strobes, bus.mem_req, bus.op_fa}, {1'b1, 15'd0, 1'b0, 4'd0});
    tick();
    chk("undef_idle", bus.in_ready, 1);

    // Reset in the middle of a LOAD wait abandons it without write-back.
    issue(LOAD, 5'd21, 5'd22, 5'd23, FA_SUM, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 7);
    tick();
    tick();
    chk("rst_mid_load_waiting", bus.mem_req, 1);
    rst = 1'b0;
    tick();
    chk("rst_mid_load_outputs", outs_all, 0);
    chk("rst_mid_load_in_ready", bus.in_ready, 1);
    exp_q.delete();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_mid_load_quiet", {bus.in_ready, bus.write_en, bus.done}, 3'b100);
    end

    // in_valid held high: JALs run back to back, three cycles apiece.
    hs_before    = hs_total;
    bus.in_valid = 1'b1;
    bus.op_class = JAL;
    bus.rd_idx   = 5'd1;
    bus.sub      = 1'b0;
    e.br = 1'b0; e.merr = 1'b0; e.wb = 1; e.len = 2;
    for (int k = 0; k < 3; k++) exp_q.push_back(e);
    for (int c = 0; c < 9; c++) begin
      chk("b2b_in_ready", bus.in_ready, (c % 3 == 0));
      if (c % 3 == 1) chk("b2b_jal_wb", strobes, S_WE | S_PCP);
      if (c == 8) bus.in_valid = 1'b0;
      tick();
    end
    chk("b2b_handshakes", hs_total - hs_before, 3);
    chk("b2b_end_idle", bus.in_ready, 1);

    tick();
    chk("sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
